// File: rtl/dm_arb_pkg.sv
// Shared encodings for the DataMemory port arbiter: FSM states and granted-port IDs.
package dm_arb_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] DMA_BURST = 2'd1;
  localparam logic [1:0] CPU_FORCE = 2'd2;

  localparam logic [1:0] PORT_NONE = 2'd0;
  localparam logic [1:0] PORT_CPU  = 2'd1;
  localparam logic [1:0] PORT_DMA  = 2'd2;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive cycles a requester waited without a grant; o_starved once it hits LIMIT.
// One-cycle registered view: the count reflects waits up to the previous cycle, so no combinational loop with the grant.
module arb_wait_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_starved
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != LIM) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_starved = (r_cnt >= LIM);

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the DataMemory port between CPU and DMA: zero-latency grants, CPU priority, locked DMA bursts, anti-starvation.
// Losing requester holds its request and is stalled; optional perf counters under DM_ARB_PERF_EN.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DM_SIZE_BIT  = 10,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [DM_SIZE_BIT-1:0] cpu_addr,
  input  logic [31:0]            cpu_wdata,
  output logic                   cpu_gnt,
  output logic                   cpu_stall,
  input  logic                   dma_req,
  input  logic                   dma_lock,
  input  logic                   dma_we,
  input  logic [DM_SIZE_BIT-1:0] dma_addr,
  input  logic [31:0]            dma_wdata,
  output logic                   dma_gnt,
  output logic                   mem_we,
  output logic [DM_SIZE_BIT-1:0] mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  output logic [31:0]            rdata
`ifdef DM_ARB_PERF_EN
  ,
  output logic [31:0]            cpu_stall_cnt,
  output logic [31:0]            dma_grant_cnt
`endif
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [BW-1:0] r_burst_cnt;
  logic [BW-1:0] w_burst_nxt;
  logic          w_cpu_starved;
  logic          w_dma_starved;
  logic          w_idle_cpu;
  logic          w_idle_dma;
  logic          w_burst_ok;
  logic          w_force;
  logic [1:0]    w_sel;

  arb_wait_counter #(.LIMIT(STARVE_LIMIT)) u_cpu_wait (
    .clk      (clk),
    .reset    (reset),
    .i_req    (cpu_req),
    .i_gnt    (cpu_gnt),
    .o_starved(w_cpu_starved)
  );

  arb_wait_counter #(.LIMIT(STARVE_LIMIT)) u_dma_wait (
    .clk      (clk),
    .reset    (reset),
    .i_req    (dma_req),
    .i_gnt    (dma_gnt),
    .o_starved(w_dma_starved)
  );

  assign w_idle_cpu = cpu_req && !(w_dma_starved && dma_req);
  assign w_idle_dma = dma_req && !w_idle_cpu;
  assign w_burst_ok = dma_req && dma_lock;
  assign w_force    = cpu_req && ((r_burst_cnt == BURST_MAX) || w_cpu_starved);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  // A burst that loses req/lock falls back to plain IDLE arbitration in the same cycle.
  always_comb begin
    w_state_nxt = IDLE;
    w_burst_nxt = r_burst_cnt;
    case (r_state)
      IDLE: begin
        if (dma_gnt && dma_lock) begin
          w_state_nxt = DMA_BURST;
          w_burst_nxt = BW'(1);
        end
      end
      DMA_BURST: begin
        if (!w_burst_ok) begin
          w_state_nxt = IDLE;
        end else if (w_force) begin
          w_state_nxt = CPU_FORCE;
        end else begin
          w_state_nxt = DMA_BURST;
          if (r_burst_cnt != BURST_MAX) w_burst_nxt = r_burst_cnt + 1'b1;
        end
      end
      CPU_FORCE: begin
        if (cpu_req) begin
          w_state_nxt = w_burst_ok ? DMA_BURST : IDLE;
          w_burst_nxt = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          cpu_gnt = w_idle_cpu;
          dma_gnt = w_idle_dma;
        end
        DMA_BURST: begin
          if (!w_burst_ok) begin
            cpu_gnt = w_idle_cpu;
            dma_gnt = w_idle_dma;
          end else if (!w_force) begin
            dma_gnt = 1'b1;
          end
        end
        CPU_FORCE: cpu_gnt = cpu_req;
        default: ;
      endcase
    end
  end

  assign cpu_stall = cpu_req && !cpu_gnt;
  assign w_sel     = cpu_gnt ? PORT_CPU : (dma_gnt ? PORT_DMA : PORT_NONE);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (w_sel)
      PORT_CPU: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      PORT_DMA: begin
        mem_we    = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  assign rdata = mem_rdata;

`ifdef DM_ARB_PERF_EN
  logic [31:0] r_cpu_stall_cnt;
  logic [31:0] r_dma_grant_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_stall_cnt <= '0;
      r_dma_grant_cnt <= '0;
    end else begin
      if (cpu_stall) r_cpu_stall_cnt <= r_cpu_stall_cnt + 32'd1;
      if (dma_gnt)   r_dma_grant_cnt <= r_dma_grant_cnt + 32'd1;
    end
  end

  assign cpu_stall_cnt = r_cpu_stall_cnt;
  assign dma_grant_cnt = r_dma_grant_cnt;
`endif

endmodule
